// File: rtl/regfile_mp_pkg.sv
// Shared types for the multi-port register file.
// Holds the init/run FSM encoding used by regfile_mp.
package regfile_mp_pkg;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port output mux for regfile_mp.
// Forwards same-cycle write data ahead of the array word; the highest-index write port wins.
module regfile_bypass_mux #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     valid,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [DATA_W-1:0]        word,
  output logic [DATA_W-1:0]        rdata,
  output logic                     hit
);

  logic [DATA_W-1:0] byp_data;
  logic              is_zero;

  assign is_zero = (ZERO_REG != 0) && (raddr == '0);

  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    // Ascending scan: a later match overrides, so the highest port wins.
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr)) begin
        hit      = 1'b1;
        byp_data = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!valid || is_zero || !re) begin
      rdata = '0;
    end else if (hit) begin
      rdata = byp_data;
    end else begin
      rdata = word;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, pending-write scoreboard and a post-reset
// clearing sweep. Reads are combinational; all state changes on posedge clk.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        pend,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [DEPTH-1:0]  sb_q, sb_d;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              rd_valid;
  logic [NUM_RD-1:0] hit;

  assign ready    = (state_q == StRun);
  assign rd_valid = ready && !rst;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        if (INIT_CLEAR == 0) begin
          state_d = StRun;
        end else if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
          // Hold the counter at the terminal value instead of wrapping.
          state_d = StRun;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StRun: state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    sb_d = sb_q;
    if (state_q == StRun) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k]) sb_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      // Set applied after clears: a new producer issued this cycle wins.
      if (sb_set) sb_d[sb_addr] = 1'b1;
    end
    if (ZERO_REG != 0) sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      sb_q       <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sb_q       <= sb_d;
    end
  end

  // Array has no reset; the sweep provides the defined contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        if (INIT_CLEAR != 0) regs[init_cnt_q] <= '0;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (we[k] && !((ZERO_REG != 0) && (waddr[k*ADDR_W +: ADDR_W] == '0))) begin
            regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_zero;

    assign ra      = raddr[i*ADDR_W +: ADDR_W];
    assign ra_zero = (ZERO_REG != 0) && (ra == '0);

    regfile_bypass_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_mux (
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .valid(rd_valid),
      .re   (re[i]),
      .raddr(ra),
      .word (regs[ra]),
      .rdata(rdata[i*DATA_W +: DATA_W]),
      .hit  (hit[i])
    );

    assign pend[i] = rd_valid && re[i] && sb_q[ra] && !hit[i] && !ra_zero;
  end

endmodule
